store_align_buffer: RTL and testbench

- Store-side counterpart of the immediate/load extension path: narrows and lane-aligns SW/SH/SB data into word-wide writes with byte enables.
- Buffers accepted stores in a small FIFO toward the system bridge using a valid/ready handshake.
- Raises an AdES exception for illegal store addresses.
- Sits at the M stage, between the pipeline and the bridge that fronts DM, TC0 and TC1.

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/store_lane_pack.sv | 78 +++++++
 rtl/store_align_buffer.sv | 121 ++++++++++++
 tb/tb_store_align_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared store-path encodings, address map defaults and FIFO entry type
//
// Purpose: constants and types used by the M-stage store path.
// Contents:
//   st_op_e      store opcode encoding (SW, SH, SB, reserved)
//   TC_WIN       byte size of each timer register window
//   TC_COUNT_OFF offset of the read-only COUNT register inside a timer window
//   *_DEF        default address map values
//   st_entry_t   one buffered bridge write (aligned address, byte enables, data)
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_RSV = 2'd3
    } st_op_e;

    localparam logic [31:0] TC_WIN       = 32'd12;
    localparam logic [31:0] TC_COUNT_OFF = 32'd8;

    localparam logic [31:0] DM_TOP_DEF   = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } st_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// rtl/store_lane_pack.sv - combinational lane packing and address-error check for stores
//
// Purpose: turns one store request into a word-wide write and flags illegal addresses.
// Ports:
//   st_op        in   2   store opcode (SW/SH/SB/reserved)
//   st_addr      in  32   byte address
//   st_data      in  32   register data
//   aligned_addr out 32   {st_addr[31:2], 2'b00}
//   byteen       out  4   byte enables
//   wdata        out 32   lane-replicated data
//   ades         out  1   address error for this store
module store_lane_pack
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] DM_TOP   = DM_TOP_DEF,
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF
) (
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic [31:0] aligned_addr,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        ades
);

    logic [31:0] off0;
    logic [31:0] off1;
    logic [31:0] tc_off;
    logic        in_dm;
    logic        in_tc0;
    logic        in_tc1;
    logic        in_tc;

    // Unsigned subtraction: addresses below a base wrap to huge offsets and
    // therefore fall outside the window without a separate lower-bound test.
    assign off0   = st_addr - TC0_BASE;
    assign off1   = st_addr - TC1_BASE;
    assign in_dm  = (st_addr <= DM_TOP);
    assign in_tc0 = (off0 < TC_WIN);
    assign in_tc1 = (off1 < TC_WIN);
    assign in_tc  = in_tc0 | in_tc1;
    assign tc_off = in_tc0 ? off0 : off1;

    assign aligned_addr = {st_addr[31:2], 2'b00};

    always_comb begin
        byteen = 4'b0000;
        wdata  = st_data;
        ades   = 1'b0;
        case (st_op)
            ST_SW: begin
                byteen = 4'b1111;
                wdata  = st_data;
                if (st_addr[1:0] != 2'b00) ades = 1'b1;
                if (in_tc && (tc_off == TC_COUNT_OFF)) ades = 1'b1;
            end
            ST_SH: begin
                byteen = st_addr[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{st_data[15:0]}};
                if (st_addr[0]) ades = 1'b1;
                // Timer registers only take full-word writes.
                if (in_tc) ades = 1'b1;
            end
            ST_SB: begin
                byteen = 4'b0001 << st_addr[1:0];
                wdata  = {4{st_data[7:0]}};
                if (in_tc) ades = 1'b1;
            end
            default: begin
                ades = 1'b1;
            end
        endcase
        if (!(in_dm || in_tc)) ades = 1'b1;
    end

endmodule

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - M-stage store buffer: lane-aligns stores and queues them to the bridge
//
// Purpose: accepts aligned stores from the pipeline, holds them in a small FIFO and
//          presents the head to the system bridge with a valid/ready handshake.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   st_req            M-stage instruction is a store
//   st_op             0=SW, 1=SH, 2=SB, 3=reserved
//   st_addr, st_data  byte address and register data
//   flush             kills this cycle's st_req
//   exc_ades          address error on the live request (combinational)
//   stall             live request cannot be accepted this cycle (combinational)
//   drained           FIFO empty
//   mem_valid         head entry valid
//   mem_addr          word-aligned head address
//   mem_byteen        head byte enables
//   mem_wdata         head write data
//   mem_ready         bridge accepts head this cycle
module store_align_buffer
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] DM_TOP   = DM_TOP_DEF,
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_req,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        flush,
    output logic        exc_ades,
    output logic        stall,
    output logic        drained,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    st_entry_t     fifo_mem [DEPTH];
    st_entry_t     last_q;
    st_entry_t     new_entry;
    st_entry_t     head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          pk_ades;
    logic          req_live;
    logic          full;
    logic          push;
    logic          pop;

    store_lane_pack #(
        .DM_TOP   (DM_TOP),
        .TC0_BASE (TC0_BASE),
        .TC1_BASE (TC1_BASE)
    ) u_pack (
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .aligned_addr (new_entry.addr),
        .byteen       (new_entry.byteen),
        .wdata        (new_entry.wdata),
        .ades         (pk_ades)
    );

    assign req_live  = st_req & ~flush;
    assign full      = (count == FULL_COUNT);
    assign mem_valid = (count != '0);
    assign drained   = (count == '0);
    assign pop       = mem_valid & mem_ready;
    assign exc_ades  = req_live & pk_ades;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push      = req_live & ~pk_ades & (~full | pop);
    assign stall     = req_live & ~pk_ades & full & ~pop;

    // With the FIFO empty the read pointer may point at a stale slot, so the
    // outputs fall back to the most recently popped entry instead.
    assign head       = mem_valid ? fifo_mem[rd_ptr] : last_q;
    assign mem_addr   = head.addr;
    assign mem_byteen = head.byteen;
    assign mem_wdata  = head.wdata;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - scoreboard bench for store_align_buffer
module tb_store_align_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_req;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        flush;
    logic        exc_ades;
    logic        stall;
    logic        drained;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [67:0] sb_q [$];

    store_align_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .st_req     (st_req),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .flush      (flush),
        .exc_ades   (exc_ades),
        .stall      (stall),
        .drained    (drained),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [67:0] act, input logic [67:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Bridge monitor: every accepted head must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_valid && mem_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 68'd1, 68'd0);
            end else begin
                logic [67:0] e;
                e = sb_q.pop_front();
                check("mem_addr",   {36'd0, mem_addr},   {36'd0, e[67:36]});
                check("mem_byteen", {64'd0, mem_byteen}, {64'd0, e[35:32]});
                check("mem_wdata",  {36'd0, mem_wdata},  {36'd0, e[31:0]});
            end
        end
    end

    // Called at posedge+1; drives one request cycle, checks the combinational
    // response at negedge and queues the expected write if it will be accepted.
    task automatic do_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic fl, input logic exp_ades, input logic exp_stall,
                            input logic [31:0] xa, input logic [3:0] xb, input logic [31:0] xd);
        st_req  = 1'b1;
        st_op   = op;
        st_addr = addr;
        st_data = data;
        flush   = fl;
        @(negedge clk);
        check("exc_ades", {67'd0, exc_ades}, {67'd0, exp_ades});
        check("stall",    {67'd0, stall},    {67'd0, exp_stall});
        if (!fl && !exp_ades && !exp_stall) sb_q.push_back({xa, xb, xd});
        @(posedge clk); #1;
        st_req = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        for (i = 0; i < 20 && !drained; i++) begin
            @(posedge clk); #1;
        end
        check(tag, {67'd0, drained}, 68'd1);
        check({tag, "_sb_empty"}, 68'(sb_q.size()), 68'd0);
    endtask

    initial begin
        reset     = 1'b1;
        st_req    = 1'b0;
        st_op     = 2'd0;
        st_addr   = '0;
        st_data   = '0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   {67'd0, mem_valid}, 68'd0);
        check("rst_drained", {67'd0, drained},   68'd1);
        check("rst_out",     {mem_addr, mem_byteen, mem_wdata}, 68'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: word store, one-cycle latency, then drained.
        mem_ready = 1'b1;
        do_store(2'd0, 32'h0000_0104, 32'h1234_5678, 1'b0, 1'b0, 1'b0,
                 32'h0000_0104, 4'b1111, 32'h1234_5678);
        check("t1_valid", {67'd0, mem_valid}, 68'd1);
        @(posedge clk); #1;
        check("t1_drained", {67'd0, drained}, 68'd1);
        check("t1_hold_addr", {36'd0, mem_addr}, {36'd0, 32'h0000_0104});

        // 2: byte and halfword lane packing.
        do_store(2'd2, 32'h0000_0203, 32'h0000_00AB, 1'b0, 1'b0, 1'b0,
                 32'h0000_0200, 4'b1000, 32'hABAB_ABAB);
        do_store(2'd1, 32'h0000_0102, 32'h0000_CAFE, 1'b0, 1'b0, 1'b0,
                 32'h0000_0100, 4'b1100, 32'hCAFE_CAFE);
        do_store(2'd2, 32'h0000_0011, 32'h1234_5677, 1'b0, 1'b0, 1'b0,
                 32'h0000_0010, 4'b0010, 32'h7777_7777);
        do_store(2'd1, 32'h0000_2FFC, 32'h8765_BEEF, 1'b0, 1'b0, 1'b0,
                 32'h0000_2FFC, 4'b0011, 32'hBEEF_BEEF);
        wait_drain("t2_drain");

        // 3: address errors never push or stall.
        do_store(2'd1, 32'h0000_0101, 32'h1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        do_store(2'd0, 32'h0000_3000, 32'h2, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        do_store(2'd2, 32'h0000_7F04, 32'h3, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        do_store(2'd0, 32'h0000_7F08, 32'h4, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        do_store(2'd3, 32'h0000_0040, 32'h5, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        do_store(2'd0, 32'h0000_0042, 32'h6, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        do_store(2'd0, 32'h0000_7F1C, 32'h7, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        check("t3_no_push", {67'd0, mem_valid}, 68'd0);
        do_store(2'd0, 32'h0000_7F14, 32'h55AA_0011, 1'b0, 1'b0, 1'b0,
                 32'h0000_7F14, 4'b1111, 32'h55AA_0011);
        wait_drain("t3_drain");

        // 4: backpressure, stall when full, simultaneous push/pop.
        mem_ready = 1'b0;
        do_store(2'd0, 32'h0000_0010, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0,
                 32'h0000_0010, 4'b1111, 32'hAAAA_0001);
        do_store(2'd0, 32'h0000_0014, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0,
                 32'h0000_0014, 4'b1111, 32'hBBBB_0002);
        do_store(2'd0, 32'h0000_0018, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        do_store(2'd0, 32'h0000_0018, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        check("t4_head_stable", {36'd0, mem_wdata}, {36'd0, 32'hAAAA_0001});
        mem_ready = 1'b1;
        do_store(2'd0, 32'h0000_0018, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0,
                 32'h0000_0018, 4'b1111, 32'hCCCC_0003);
        check("t4_count_full", {67'd0, mem_valid}, 68'd1);
        wait_drain("t4_drain");

        // 5: reset with entries pending drops them all.
        mem_ready = 1'b0;
        do_store(2'd2, 32'h0000_0020, 32'h0000_0011, 1'b0, 1'b0, 1'b0,
                 32'h0000_0020, 4'b0001, 32'h1111_1111);
        do_store(2'd2, 32'h0000_0021, 32'h0000_0022, 1'b0, 1'b0, 1'b0,
                 32'h0000_0020, 4'b0010, 32'h2222_2222);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_valid",   {67'd0, mem_valid}, 68'd0);
        check("t5_drained", {67'd0, drained},   68'd1);
        check("t5_out",     {mem_addr, mem_byteen, mem_wdata}, 68'd0);
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_quiet", {67'd0, mem_valid}, 68'd0);

        // 6: flush kills the request but not committed entries.
        mem_ready = 1'b0;
        do_store(2'd0, 32'h0000_0080, 32'hD00D_0080, 1'b0, 1'b0, 1'b0,
                 32'h0000_0080, 4'b1111, 32'hD00D_0080);
        do_store(2'd0, 32'h0000_0084, 32'hDEAD_0084, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        do_store(2'd0, 32'h0000_0088, 32'hF00D_0088, 1'b0, 1'b0, 1'b0,
                 32'h0000_0088, 4'b1111, 32'hF00D_0088);
        do_store(2'd0, 32'h0000_008C, 32'hDEAD_008C, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("t6_pending", {67'd0, drained}, 68'd0);
        mem_ready = 1'b1;
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
